// File: rtl/display_pkg.sv
// rtl/display_pkg.sv - glyph geometry, font types and pipeline stage record shared by the text renderer
package display_pkg;

    localparam int CHAR_W      = 8;
    localparam int CHAR_H      = 16;
    localparam int FONT_ROW_W  = 4;
    localparam int CHAR_CODE_W = 8;
    localparam int XBIT_W      = $clog2(CHAR_W);

    typedef logic [CHAR_CODE_W-1:0] char_code_t;
    typedef logic [CHAR_W-1:0]      font_line_t;
    typedef logic [FONT_ROW_W-1:0]  font_row_t;

    // Per-pixel state carried between pipeline stages
    typedef struct packed {
        logic [XBIT_W-1:0] xbit;
        font_row_t         yrow;
        logic              act;
        logic              inr;
        logic              hs;
        logic              vs;
`ifdef TEXT_CURSOR_EN
        logic [6:0]        ccol;
        logic [4:0]        crow;
`endif
    } stage_t;

    function automatic stage_t stage_reset(input logic sync_lvl);
        stage_t s;
        s    = '0;
        s.hs = sync_lvl;
        s.vs = sync_lvl;
        return s;
    endfunction

endpackage

// File: rtl/text_renderer_if.sv
// rtl/text_renderer_if.sv - timing-gen, char-buffer, font-ROM and pixel-out signals of the text renderer (cursor ports via TEXT_CURSOR_EN)
interface text_renderer_if #(
    parameter int XY_W   = 10,
    parameter int ADDR_W = 12
);
    import display_pkg::*;

    logic [XY_W-1:0]   iPixX;
    logic [XY_W-1:0]   iPixY;
    logic              iActive;
    logic              iHSync;
    logic              iVSync;
    logic [ADDR_W-1:0] oCharAddr;
    char_code_t        iCharCode;
    char_code_t        oFontChar;
    font_row_t         oFontRow;
    font_line_t        iFontLine;
    logic              oPixel;
    logic              oActive;
    logic              oHSync;
    logic              oVSync;
`ifdef TEXT_CURSOR_EN
    logic [6:0]        iCursorCol;
    logic [4:0]        iCursorRow;
    logic              iCursorOn;
`endif

    modport slave (
        input  iPixX, iPixY, iActive, iHSync, iVSync, iCharCode, iFontLine,
        output oCharAddr, oFontChar, oFontRow, oPixel, oActive, oHSync, oVSync
`ifdef TEXT_CURSOR_EN
        , input iCursorCol, iCursorRow, iCursorOn
`endif
    );

    modport master (
        output iPixX, iPixY, iActive, iHSync, iVSync, iCharCode, iFontLine,
        input  oCharAddr, oFontChar, oFontRow, oPixel, oActive, oHSync, oVSync
`ifdef TEXT_CURSOR_EN
        , output iCursorCol, iCursorRow, iCursorOn
`endif
    );

endinterface

// File: rtl/text_renderer_blink.sv
// rtl/text_renderer_blink.sv - text_blink_timer: vsync-rising frame counter and cursor blink phase (built only with TEXT_CURSOR_EN)
`ifdef TEXT_CURSOR_EN
module text_blink_timer #(
    parameter logic SYNC_RST = 1'b1
) (
    input  logic iClk,
    input  logic iRst,
    input  logic iVSync,
    output logic oPhase
);
    logic       vs_prev_d, vs_prev_q;
    logic [4:0] count_d, count_q;
    logic       phase_d, phase_q;
    logic       rise;

    // Counter wraps every 32 frames; the wrap is the phase toggle point
    always_comb begin
        rise      = iVSync & ~vs_prev_q;
        vs_prev_d = iVSync;
        count_d   = count_q + 5'(rise);
        phase_d   = phase_q ^ (rise & (count_q == 5'd31));
    end

    always_ff @(posedge iClk) begin
        if (iRst) begin
            vs_prev_q <= SYNC_RST;
            count_q   <= '0;
            phase_q   <= 1'b1;
        end else begin
            vs_prev_q <= vs_prev_d;
            count_q   <= count_d;
            phase_q   <= phase_d;
        end
    end

    assign oPhase = phase_q;

endmodule
`endif

// File: rtl/text_renderer.sv
// rtl/text_renderer.sv - 3-stage text pipeline: cell address, font lookup, pixel serialise; TEXT_CURSOR_EN adds blinking cursor
module text_renderer
    import display_pkg::*;
#(
    parameter int   COLS     = 80,
    parameter int   ROWS     = 30,
    parameter int   XY_W     = 10,
    parameter int   ADDR_W   = 12,
    parameter logic SYNC_RST = 1'b1
) (
    input logic            iClk,
    input logic            iRst,
    text_renderer_if.slave bus
);
    localparam int XSH = $clog2(CHAR_W);
    localparam int YSH = $clog2(CHAR_H);

    logic [XY_W-1:0]   col;
    logic [XY_W-1:0]   row;
    logic              in_range;
    logic [ADDR_W-1:0] char_addr_d, char_addr_q;
    stage_t            s1_d, s1_q;
    stage_t            s2_d, s2_q;
    logic              pix_d, pix_q;
    logic              act_d, act_q;
    logic              hs_d, hs_q;
    logic              vs_d, vs_q;
    logic              glyph_bit;
    logic              cursor_hit;

`ifdef TEXT_CURSOR_EN
    logic blink_phase;

    text_blink_timer #(
        .SYNC_RST (SYNC_RST)
    ) u_blink (
        .iClk   (iClk),
        .iRst   (iRst),
        .iVSync (bus.iVSync),
        .oPhase (blink_phase)
    );
`endif

    // Stage 1: cell address; out-of-range cells read address 0 instead of wrapping
    always_comb begin
        col         = bus.iPixX >> XSH;
        row         = bus.iPixY >> YSH;
        in_range    = (col < XY_W'(COLS)) && (row < XY_W'(ROWS));
        char_addr_d = '0;
        if (in_range) begin
            char_addr_d = ADDR_W'(row) * ADDR_W'(COLS) + ADDR_W'(col);
        end
        s1_d      = '0;
        s1_d.xbit = bus.iPixX[XBIT_W-1:0];
        s1_d.yrow = bus.iPixY[FONT_ROW_W-1:0];
        s1_d.act  = bus.iActive;
        s1_d.inr  = in_range;
        s1_d.hs   = bus.iHSync;
        s1_d.vs   = bus.iVSync;
`ifdef TEXT_CURSOR_EN
        s1_d.ccol = 7'(col);
        s1_d.crow = 5'(row);
`endif
    end

    // Stage 2 holds the glyph row while the char code returns; stage 3 picks the bit
    always_comb begin
        s2_d       = s1_q;
        glyph_bit  = bus.iFontLine[~s2_q.xbit];
        cursor_hit = 1'b0;
`ifdef TEXT_CURSOR_EN
        cursor_hit = blink_phase & bus.iCursorOn
                   & (s2_q.ccol == bus.iCursorCol)
                   & (s2_q.crow == bus.iCursorRow)
                   & (s2_q.yrow[FONT_ROW_W-1:1] == 3'b111);
`endif
        pix_d = s2_q.act & s2_q.inr & (glyph_bit ^ cursor_hit);
        act_d = s2_q.act;
        hs_d  = s2_q.hs;
        vs_d  = s2_q.vs;
    end

    always_ff @(posedge iClk) begin
        if (iRst) begin
            char_addr_q <= '0;
            s1_q        <= stage_reset(SYNC_RST);
            s2_q        <= stage_reset(SYNC_RST);
            pix_q       <= 1'b0;
            act_q       <= 1'b0;
            hs_q        <= SYNC_RST;
            vs_q        <= SYNC_RST;
        end else begin
            char_addr_q <= char_addr_d;
            s1_q        <= s1_d;
            s2_q        <= s2_d;
            pix_q       <= pix_d;
            act_q       <= act_d;
            hs_q        <= hs_d;
            vs_q        <= vs_d;
        end
    end

    assign bus.oCharAddr = char_addr_q;
    assign bus.oFontChar = bus.iCharCode;
    assign bus.oFontRow  = s2_q.yrow;
    assign bus.oPixel    = pix_q;
    assign bus.oActive   = act_q;
    assign bus.oHSync    = hs_q;
    assign bus.oVSync    = vs_q;

endmodule
